// File: rtl/gpu_pixel_writebuf.sv
// Pixel write buffer: queues rasterised pixels and turns each into one framebuffer SRAM write.
// Optional GPU_PIXBUF_BOUNDS_CHECK_EN drops off-screen pixels and counts them on drop_count.
//
// state       | meaning
// ------------+---------------------------------------------------
// S_IDLE      | no access; ce_n/we_n high, addr/data hold
// S_SETUP     | pixel address/data presented, ce_n low, we_n high
// S_WRITE     | we_n low for WAIT_CYCLES cycles
// S_CLR_SETUP | clear address/data presented, ce_n low, we_n high
// S_CLR_WRITE | we_n low for WAIT_CYCLES cycles, then next clear address
module gpu_pixel_writebuf #(
    parameter int CHANNEL_BITS = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int WIDTH_BITS   = 9,
    parameter int HEIGHT_BITS  = 9,
    parameter int FB_WIDTH     = 480,
    parameter int FB_HEIGHT    = 272,
    parameter int FIFO_DEPTH   = 8,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    input  logic [WIDTH_BITS-1:0]                  pix_x,
    input  logic [HEIGHT_BITS-1:0]                 pix_y,
    input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0]   pix_color,
    input  logic                                   flush_req,
    input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0]   clear_color,
    output logic                                   flush_busy,
    output logic [WIDTH_BITS+HEIGHT_BITS-1:0]      sram_addr,
    output logic [NUM_CHANNELS*CHANNEL_BITS-1:0]   sram_data,
    output logic                                   sram_ce_n,
    output logic                                   sram_we_n,
    output logic                                   sram_oe_n,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count
`ifdef GPU_PIXBUF_BOUNDS_CHECK_EN
    ,
    output logic [15:0]                            drop_count
`endif
);

    localparam int DW    = NUM_CHANNELS * CHANNEL_BITS;
    localparam int AW    = WIDTH_BITS + HEIGHT_BITS;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WW    = $clog2(WAIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [AW-1:0]    CLR_LAST  = AW'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [WW-1:0]    WAIT_LOAD = WW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_CLR_SETUP,
        S_CLR_WRITE
    } state_t;

    state_t            state;
    logic [WW-1:0]     wait_cnt;
    logic [DW-1:0]     clear_latch;

    logic [AW-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DW-1:0]     fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [AW-1:0]     push_addr;

    assign sram_oe_n  = 1'b1;
    assign fifo_empty = (fifo_count == '0);
    assign pix_ready  = (fifo_count != FULL_CNT) && !flush_busy;
    assign accept     = pix_valid && pix_ready;
    assign push_addr  = AW'(pix_y) * AW'(FB_WIDTH) + AW'(pix_x);

`ifdef GPU_PIXBUF_BOUNDS_CHECK_EN
    localparam logic [31:0] FB_W_U = 32'(FB_WIDTH);
    localparam logic [31:0] FB_H_U = 32'(FB_HEIGHT);

    logic in_range;

    assign in_range = (32'(pix_x) < FB_W_U) && (32'(pix_y) < FB_H_U);
    assign push     = accept && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign push = accept;
`endif

    // The head entry is consumed on the same edge that loads it onto the SRAM bus.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || (state == S_WRITE && wait_cnt == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= pix_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            clear_latch <= '0;
            flush_busy  <= 1'b0;
            sram_addr   <= '0;
            sram_data   <= '0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            if (flush_req && !flush_busy) begin
                flush_busy  <= 1'b1;
                clear_latch <= clear_color;
            end

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= S_SETUP;
                        sram_ce_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        sram_addr <= fifo_addr[rd_ptr];
                        sram_data <= fifo_data[rd_ptr];
                    end else if (flush_busy) begin
                        state     <= S_CLR_SETUP;
                        sram_ce_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        sram_addr <= '0;
                        sram_data <= clear_latch;
                    end
                end

                S_SETUP: begin
                    state     <= S_WRITE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= WAIT_LOAD;
                end

                S_WRITE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end else if (!fifo_empty) begin
                        state     <= S_SETUP;
                        sram_we_n <= 1'b1;
                        sram_addr <= fifo_addr[rd_ptr];
                        sram_data <= fifo_data[rd_ptr];
                    end else begin
                        state     <= S_IDLE;
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                    end
                end

                S_CLR_SETUP: begin
                    state     <= S_CLR_WRITE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= WAIT_LOAD;
                end

                S_CLR_WRITE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end else if (sram_addr == CLR_LAST) begin
                        state      <= S_IDLE;
                        sram_ce_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        flush_busy <= 1'b0;
                    end else begin
                        state     <= S_CLR_SETUP;
                        sram_we_n <= 1'b1;
                        sram_addr <= sram_addr + AW'(1);
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    sram_ce_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
